multiport_address_translation_table: RTL

Next-generation literal-to-clause address translation table. Each entry holds a clause table address and a clause mask. It provides READ_PORTS independent read ports with valid-qualified, configurable-latency outputs, and a hardware clear sweep that zeroes the whole table after reset or on request. It sits between the variable/literal selection logic and the clause table, so several literals can be resolved per cycle. The table is loaded over the AXI setup write port.

---
 rtl/multiport_address_translation_table_pkg.sv | 22 ++
 rtl/multiport_address_translation_table_bank.sv | 50 +++++
 rtl/multiport_address_translation_table.sv | 135 +++++++++++++
 3 files changed

// File: rtl/multiport_address_translation_table_pkg.sv
// Shared types and helpers for the literal-to-clause address translation table.
// An entry is {clause table address, clause mask} with the mask in the low bits.
package multiport_address_translation_table_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } att_state_t;

  localparam int ATT_ENTRY_WIDTH = 11 + 20;

  function automatic int att_entry_width(input int clause_table_address_width,
                                         input int clause_count);
    return clause_table_address_width + clause_count;
  endfunction

  // Bit position of the lowest clause-address bit inside an entry.
  function automatic int att_addr_lsb(input int clause_count);
    return clause_count;
  endfunction

endpackage

// File: rtl/multiport_address_translation_table_bank.sv
// One read-port bank: simple dual-port RAM, read-first, with an optional
// output register when READ_LATENCY is 2.
module att_bank #(
  parameter int AW           = 12,
  parameter int DW           = 31,
  parameter int READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] q1;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Nonblocking write above makes a same-cycle read return the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q1 <= '0;
    else if (re) q1 <= mem[raddr];
  end

  generate
    if (READ_LATENCY == 2) begin : g_out_reg
      logic          re_q;
      logic [DW-1:0] q2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          re_q <= 1'b0;
          q2   <= '0;
        end else begin
          re_q <= re;
          if (re_q) q2 <= q1;
        end
      end
      assign rdata = q2;
    end else begin : g_no_reg
      assign rdata = q1;
    end
  endgenerate

endmodule

// File: rtl/multiport_address_translation_table.sv
// Multi-port literal-to-clause translation table: replicated banks share one
// setup write port; a clear sweep zeroes every entry after reset or on request.
module multiport_address_translation_table
  import multiport_address_translation_table_pkg::*;
#(
  parameter int CLAUSE_COUNT               = 20,
  parameter int LITERAL_ADDRESS_WIDTH      = 12,
  parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
  parameter int READ_PORTS                 = 2,
  parameter int READ_LATENCY               = 1
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             clear_i,
  output logic                                             busy_o,
  input  logic                                             axi_wr_en_i,
  input  logic [LITERAL_ADDRESS_WIDTH-1:0]                 axi_wr_addr_i,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0] axi_wr_data_i,
  output logic                                             wr_err_o,
  output logic [LITERAL_ADDRESS_WIDTH:0]                   entries_written_o,
  input  logic [READ_PORTS-1:0]                            rd_valid_i,
  input  logic [READ_PORTS*LITERAL_ADDRESS_WIDTH-1:0]      rd_addr_i,
  output logic [READ_PORTS-1:0]                            rd_valid_o,
  output logic [READ_PORTS*CLAUSE_TABLE_ADDRESS_WIDTH-1:0] addr_o,
  output logic [READ_PORTS*CLAUSE_COUNT-1:0]               mask_o
);

  localparam int LAW    = LITERAL_ADDRESS_WIDTH;
  localparam int CTAW   = CLAUSE_TABLE_ADDRESS_WIDTH;
  localparam int CC     = CLAUSE_COUNT;
  localparam int EW     = att_entry_width(CTAW, CC);
  localparam int A_LSB  = att_addr_lsb(CC);
  localparam int DEPTH  = 1 << LAW;

  att_state_t      state, state_next;
  logic [LAW-1:0]  ptr;
  logic [LAW:0]    count;
  logic            bank_we;
  logic [LAW-1:0]  bank_waddr;
  logic [EW-1:0]   bank_wdata;
  logic [READ_PORTS-1:0] rd_accept;
  logic [READ_PORTS-1:0] valid_s1;
  logic [EW-1:0]   bank_rdata [READ_PORTS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (ptr == LAW'(DEPTH - 1)) state_next = ST_IDLE;
      ST_IDLE:  if (clear_i)                state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // The sweep owns the shared write port while clearing.
  always_comb begin
    busy_o     = 1'b0;
    bank_we    = 1'b0;
    bank_waddr = axi_wr_addr_i;
    bank_wdata = axi_wr_data_i;
    case (state)
      ST_CLEAR: begin
        busy_o     = 1'b1;
        bank_we    = 1'b1;
        bank_waddr = ptr;
        bank_wdata = '0;
      end
      default: bank_we = axi_wr_en_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr      <= '0;
      count    <= '0;
      wr_err_o <= 1'b0;
    end else begin
      wr_err_o <= axi_wr_en_i && (state == ST_CLEAR);
      if (state == ST_CLEAR) begin
        ptr <= ptr + 1'b1;
      end else begin
        ptr <= '0;
        if (clear_i)
          count <= '0;
        else if (axi_wr_en_i && count != (LAW+1)'(DEPTH))
          count <= count + 1'b1;
      end
    end
  end

  assign entries_written_o = count;
  assign rd_accept = rd_valid_i & {READ_PORTS{state == ST_IDLE}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_s1 <= '0;
    else       valid_s1 <= rd_accept;
  end

  generate
    if (READ_LATENCY == 2) begin : g_valid2
      logic [READ_PORTS-1:0] valid_s2;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) valid_s2 <= '0;
        else       valid_s2 <= valid_s1;
      end
      assign rd_valid_o = valid_s2;
    end else begin : g_valid1
      assign rd_valid_o = valid_s1;
    end
  endgenerate

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_bank
    att_bank #(
      .AW           (LAW),
      .DW           (EW),
      .READ_LATENCY (READ_LATENCY)
    ) u_bank (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (rd_accept[p]),
      .raddr (rd_addr_i[p*LAW +: LAW]),
      .rdata (bank_rdata[p])
    );
    assign addr_o[p*CTAW +: CTAW] = bank_rdata[p][A_LSB +: CTAW];
    assign mask_o[p*CC +: CC]     = bank_rdata[p][CC-1:0];
  end

endmodule
